spram_arbiter: RTL and testbench

- Shares one single-ported SPRAM (SB_SPRAM256KA-style: 14-bit address, 16-bit data, 4-bit nibble write mask) between two requesters, A and B.
- Typical pairing: A is the FIFO write side (UART receive path) and B is the FIFO read / transmit path. These can no longer collide on the same cycle.
- Provides a per-cycle request/grant handshake, round-robin fairness with bounded burst locking, and a 1-cycle read-return path tagged per requester.

---
 rtl/spram_pkg.sv | 19 +
 rtl/rr_lock_arb2.sv | 83 ++++++++
 rtl/spram_arbiter.sv | 84 ++++++++
 tb/tb_spram_arbiter.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spram_pkg.sv
// Shared constants and requester encoding for the SPRAM arbiter slice.
package spram_pkg;

   localparam int SPRAM_ADDR_W = 14;
   localparam int SPRAM_DATA_W = 16;
   localparam logic [3:0] SPRAM_MASK_ALL = 4'b1111;

   // Requester identity, also used as the "last granted" record.
   typedef enum logic {
      REQ_A = 1'b0,
      REQ_B = 1'b1
   } req_id_t;

   // Burst counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/rr_lock_arb2.sv
// Two-way round-robin arbiter with a burst lock that is capped at
// MAX_BURST consecutive grants while the other side is waiting.
module rr_lock_arb2
   import spram_pkg::*;
#(
   parameter int MAX_BURST = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic a_req,
   input  logic a_lock,
   input  logic b_req,
   input  logic b_lock,
   output logic a_gnt,
   output logic b_gnt,
   output logic last
);

   localparam logic [7:0] MAX_BURST_8 = 8'(MAX_BURST);

   req_id_t    last_q;
   logic       lock_active;
   logic [7:0] burst_cnt;

   req_id_t    pick;
   logic       any_gnt;
   logic       win_lock;
   logic       other_req;
   logic [7:0] run_len;

   // Choose the winner from the live requests and the registered history.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      pick      = REQ_A;
      win_lock  = 1'b0;
      other_req = 1'b0;
      run_len   = 8'd1;

      if (a_req && !b_req) begin
         pick = REQ_A;
      end else if (b_req && !a_req) begin
         pick = REQ_B;
      end else if (lock_active) begin
         pick = last_q;
      end else begin
         pick = (last_q == REQ_A) ? REQ_B : REQ_A;
      end

      win_lock  = (pick == REQ_A) ? a_lock : b_lock;
      other_req = (pick == REQ_A) ? b_req  : a_req;

      // A run continues only if the same side was also accepted last cycle.
      if (pick == last_q && burst_cnt != 8'd0) begin
         run_len = sat_inc8(burst_cnt);
      end

      // NOTE: reset is folded into the grant combinationally so it drops the
      // grant the instant reset rises, not at the next clock edge.
      any_gnt = (a_req || b_req) && !reset;
      a_gnt   = any_gnt && (pick == REQ_A);
      b_gnt   = any_gnt && (pick == REQ_B);
   end

   // Track last winner, run length and whether the winner keeps the lock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: sequential state uses non-blocking assignments only.
         last_q      <= REQ_B;
         lock_active <= 1'b0;
         burst_cnt   <= 8'd0;
      end else if (any_gnt) begin
         last_q      <= pick;
         burst_cnt   <= run_len;
         lock_active <= win_lock && ((run_len < MAX_BURST_8) || !other_req);
      end else begin
         lock_active <= 1'b0;
         burst_cnt   <= 8'd0;
      end
   end

   assign last = last_q;

endmodule

// File: rtl/spram_arbiter.sv
// Shares one single-ported SPRAM between requesters A and B: grant logic,
// address/data mux toward the RAM, and a one-cycle tagged read return.
module spram_arbiter
   import spram_pkg::*;
#(
   parameter int ADDR_W    = SPRAM_ADDR_W,
   parameter int DATA_W    = SPRAM_DATA_W,
   parameter int MAX_BURST = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              a_req,
   input  logic              a_lock,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   input  logic [3:0]        a_mask,
   output logic              a_gnt,
   output logic              a_rvalid,
   input  logic              b_req,
   input  logic              b_lock,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   input  logic [3:0]        b_mask,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic [3:0]        ram_mask,
   output logic              ram_we,
   output logic              ram_cs,
   input  logic [DATA_W-1:0] ram_rdata
);

   logic last;
   logic sel_b;

   rr_lock_arb2 #(
      .MAX_BURST (MAX_BURST)
   ) u_arb (
      .clk    (clk),
      .reset  (reset),
      .a_req  (a_req),
      .a_lock (a_lock),
      .b_req  (b_req),
      .b_lock (b_lock),
      .a_gnt  (a_gnt),
      .b_gnt  (b_gnt),
      .last   (last)
   );

   // Steer the granted side onto the RAM; when idle the address follows
   // the last winner and no write can occur.
   always_comb begin
      sel_b     = b_gnt ? 1'b1 : (a_gnt ? 1'b0 : (last == REQ_B));
      ram_cs    = a_gnt || b_gnt;
      ram_addr  = sel_b ? b_addr  : a_addr;
      ram_wdata = sel_b ? b_wdata : a_wdata;
      ram_we    = 1'b0;
      ram_mask  = 4'b0000;
      if (a_gnt) begin
         ram_we   = a_we;
         ram_mask = a_mask;
      end else if (b_gnt) begin
         ram_we   = b_we;
         ram_mask = b_mask;
      end
      rdata = ram_rdata;
   end

   // Accepted reads return on the following cycle, tagged by requester.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_rvalid <= 1'b0;
         b_rvalid <= 1'b0;
      end else begin
         a_rvalid <= a_gnt && !a_we;
         b_rvalid <= b_gnt && !b_we;
      end
   end

endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: SPRAM stand-in, rule-level reference model
// checked every cycle, and directed vectors with literal expectations.
module tb_spram_arbiter;

   localparam int MAX_BURST = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_req, a_lock, a_we;
   logic [13:0] a_addr;
   logic [15:0] a_wdata;
   logic [3:0]  a_mask;
   logic        a_gnt, a_rvalid;
   logic        b_req, b_lock, b_we;
   logic [13:0] b_addr;
   logic [15:0] b_wdata;
   logic [3:0]  b_mask;
   logic        b_gnt, b_rvalid;
   logic [15:0] rdata;
   logic [13:0] ram_addr;
   logic [15:0] ram_wdata;
   logic [3:0]  ram_mask;
   logic        ram_we, ram_cs;
   logic [15:0] ram_rdata = 16'h0000;

   int n_checks = 0;
   int n_pass   = 0;

   spram_arbiter #(.MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_lock(a_lock), .a_we(a_we), .a_addr(a_addr),
      .a_wdata(a_wdata), .a_mask(a_mask), .a_gnt(a_gnt), .a_rvalid(a_rvalid),
      .b_req(b_req), .b_lock(b_lock), .b_we(b_we), .b_addr(b_addr),
      .b_wdata(b_wdata), .b_mask(b_mask), .b_gnt(b_gnt), .b_rvalid(b_rvalid),
      .rdata(rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_mask(ram_mask), .ram_we(ram_we), .ram_cs(ram_cs),
      .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // SPRAM stand-in: registered read port, nibble-masked writes.
   logic [15:0] mem [0:16383];
   initial for (int i = 0; i < 16384; i++) mem[i] = 16'h0000;

   always @(posedge clk) begin
      if (ram_cs) begin
         if (ram_we) begin
            logic [15:0] w;
            w = mem[ram_addr];
            for (int n = 0; n < 4; n++) if (ram_mask[n]) w[4*n +: 4] = ram_wdata[4*n +: 4];
            mem[ram_addr] <= w;
         end else begin
            ram_rdata <= mem[ram_addr];
         end
      end
   end

   // Reference model: who wins under the sharing rules, what the RAM sees,
   // and which read data must come back one cycle later.
   int          m_last   = 1;   // 0 = A, 1 = B
   bit          m_held   = 0;
   int          m_streak = 0;
   bit          m_pend_a = 0;
   bit          m_pend_b = 0;
   logic [15:0] m_pend_data = 16'h0000;
   logic [15:0] exp_mem [int];

   always @(negedge clk) begin
      int          w;
      logic        w_we, w_lock, w_other;
      logic [13:0] w_addr;
      logic [15:0] w_data, cur;
      logic [3:0]  w_mask;
      if (reset) begin
         check("rst_a_gnt", a_gnt, 0);
         check("rst_b_gnt", b_gnt, 0);
         check("rst_ram_cs", ram_cs, 0);
         check("rst_ram_we", ram_we, 0);
         check("rst_a_rvalid", a_rvalid, 0);
         check("rst_b_rvalid", b_rvalid, 0);
         m_last = 1; m_held = 0; m_streak = 0; m_pend_a = 0; m_pend_b = 0;
      end else begin
         check("m_a_rvalid", a_rvalid, m_pend_a);
         check("m_b_rvalid", b_rvalid, m_pend_b);
         if (m_pend_a || m_pend_b) check("m_rdata", rdata, m_pend_data);

         if (a_req && !b_req)      w = 0;
         else if (b_req && !a_req) w = 1;
         else if (a_req && b_req)  w = m_held ? m_last : 1 - m_last;
         else                      w = -1;

         check("m_a_gnt", a_gnt, w == 0);
         check("m_b_gnt", b_gnt, w == 1);
         check("m_ram_cs", ram_cs, w >= 0);

         m_pend_a = 0; m_pend_b = 0;
         if (w < 0) begin
            check("m_idle_we", ram_we, 0);
            check("m_idle_mask", ram_mask, 0);
            check("m_idle_addr", ram_addr, m_last == 1 ? b_addr : a_addr);
            m_held = 0; m_streak = 0;
         end else begin
            w_we    = (w == 0) ? a_we    : b_we;
            w_lock  = (w == 0) ? a_lock  : b_lock;
            w_other = (w == 0) ? b_req   : a_req;
            w_addr  = (w == 0) ? a_addr  : b_addr;
            w_data  = (w == 0) ? a_wdata : b_wdata;
            w_mask  = (w == 0) ? a_mask  : b_mask;
            check("m_ram_we", ram_we, w_we);
            check("m_ram_addr", ram_addr, w_addr);
            check("m_ram_mask", ram_mask, w_mask);
            if (w_we) check("m_ram_wdata", ram_wdata, w_data);

            m_streak = (w == m_last && m_streak > 0) ? m_streak + 1 : 1;
            m_held   = w_lock && ((m_streak < MAX_BURST) || !w_other);
            m_last   = w;

            cur = exp_mem.exists(int'(w_addr)) ? exp_mem[int'(w_addr)] : 16'h0000;
            if (w_we) begin
               for (int n = 0; n < 4; n++) if (w_mask[n]) cur[4*n +: 4] = w_data[4*n +: 4];
               exp_mem[int'(w_addr)] = cur;
            end else begin
               m_pend_data = cur;
               if (w == 0) m_pend_a = 1; else m_pend_b = 1;
            end
         end
      end
   end

   task automatic idle_inputs();
      a_req = 0; a_lock = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_mask = '0;
      b_req = 0; b_lock = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_mask = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [5:0] seq_a, seq_b;
      logic [8:0] seq_burst;

      // Reset with a request pending: grant must stay low.
      reset = 1'b1;
      idle_inputs();
      a_req = 1; a_we = 1;
      @(negedge clk);
      check("reset_a_gnt", a_gnt, 0);
      check("reset_ram_cs", ram_cs, 0);
      tick();
      idle_inputs();
      reset = 1'b0;

      // A write of 0xBEEF to 0x0010.
      a_req = 1; a_we = 1; a_addr = 14'h0010; a_wdata = 16'hBEEF; a_mask = 4'hF;
      @(negedge clk);
      check("wr_a_gnt", a_gnt, 1);
      check("wr_ram_cs", ram_cs, 1);
      check("wr_ram_we", ram_we, 1);
      check("wr_ram_addr", ram_addr, 14'h0010);
      check("wr_b_gnt", b_gnt, 0);
      tick();

      // Read it back: data returns exactly one cycle later.
      a_we = 0;
      @(negedge clk);
      check("rd_a_gnt", a_gnt, 1);
      check("rd_same_cycle_rvalid", a_rvalid, 0);
      tick();
      idle_inputs();
      @(negedge clk);
      check("rd_a_rvalid", a_rvalid, 1);
      check("rd_rdata", rdata, 16'hBEEF);
      check("rd_b_rvalid", b_rvalid, 0);
      tick();
      @(negedge clk);
      check("rd_rvalid_one_cycle", a_rvalid, 0);
      tick();

      // One B access so A wins the following tie, then six contended cycles.
      b_req = 1; b_addr = 14'h0030;
      tick();
      a_req = 1; a_addr = 14'h0010;
      seq_a = '0; seq_b = '0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         seq_a = {seq_a[4:0], a_gnt};
         seq_b = {seq_b[4:0], b_gnt};
         tick();
      end
      check("alt_seq_a", seq_a, 6'b101010);
      check("alt_seq_b", seq_b, 6'b010101);

      // A bursts with lock while B waits: 8 grants to A, then B.
      a_lock = 1;
      seq_burst = '0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         seq_burst = {seq_burst[7:0], a_gnt};
         tick();
      end
      check("burst_seq_a", seq_burst, 9'b111111110);
      idle_inputs();
      tick();

      // Lock held alone beyond MAX_BURST, then B joins, then A lets go.
      a_req = 1; a_lock = 1; a_we = 1; a_addr = 14'h0100; a_wdata = 16'hA5A5; a_mask = 4'hF;
      repeat (10) tick();
      b_req = 1; b_addr = 14'h0100;
      repeat (4) tick();
      a_req = 0;
      repeat (2) tick();
      idle_inputs();
      tick();

      // Asynchronous reset in the middle of an A read grant.
      a_req = 1; a_we = 0; a_addr = 14'h0010;
      #1;
      check("pre_rst_a_gnt", a_gnt, 1);
      check("pre_rst_ram_cs", ram_cs, 1);
      reset = 1'b1;
      #1;
      check("async_rst_a_gnt", a_gnt, 0);
      check("async_rst_ram_cs", ram_cs, 0);
      check("async_rst_ram_we", ram_we, 0);
      idle_inputs();
      tick();
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_no_rvalid", a_rvalid, 0);
      tick();
      a_req = 1; b_req = 1; a_addr = 14'h0010; b_addr = 14'h0030;
      @(negedge clk);
      check("post_rst_tie_a", a_gnt, 1);
      check("post_rst_tie_b", b_gnt, 0);
      check("post_rst_no_rvalid2", a_rvalid, 0);
      tick();
      idle_inputs();
      tick();

      // Masked write by B over 0xFFFF, read by A, B writes while A's data returns.
      a_req = 1; a_we = 1; a_addr = 14'h0020; a_wdata = 16'hFFFF; a_mask = 4'hF;
      tick();
      idle_inputs();
      b_req = 1; b_we = 1; b_addr = 14'h0020; b_wdata = 16'h1234; b_mask = 4'b0011;
      tick();
      idle_inputs();
      a_req = 1; a_we = 0; a_addr = 14'h0020;
      @(negedge clk);
      check("mask_rd_a_gnt", a_gnt, 1);
      tick();
      idle_inputs();
      b_req = 1; b_we = 1; b_addr = 14'h0040; b_wdata = 16'h5555; b_mask = 4'hF;
      @(negedge clk);
      check("overlap_a_rvalid", a_rvalid, 1);
      check("overlap_b_gnt", b_gnt, 1);
      check("mask_rdata", rdata, 16'hFF34);
      tick();
      idle_inputs();
      repeat (3) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
